// File: rtl/alu_uart_requester.sv
// Host-side requester for the UART ALU link: ships A, opcode and B through Tx_uart,
// then waits for the single result byte from Rx_uart or gives up after TIMEOUT cycles.
module alu_uart_requester #(
   parameter int NB_BITS    = 8,
   parameter int NB_TIMEOUT = 18,
   parameter int TIMEOUT    = 200000
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic [NB_BITS-1:0] i_op_a,
   input  logic [NB_BITS-1:0] i_op_b,
   input  logic [NB_BITS-1:0] i_opcode,
   output logic               o_busy,
   output logic [NB_BITS-1:0] o_result,
   output logic               o_valid,
   output logic               o_timeout,
   output logic [NB_BITS-1:0] o_tx_data,
   output logic               o_tx_start,
   input  logic               i_tx_done,
   input  logic [NB_BITS-1:0] i_rx_data,
   input  logic               i_rx_done
);

   localparam logic [3:0] ST_IDLE     = 4'd0;
   localparam logic [3:0] ST_SEND_A   = 4'd1;
   localparam logic [3:0] ST_WAIT_A   = 4'd2;
   localparam logic [3:0] ST_SEND_OP  = 4'd3;
   localparam logic [3:0] ST_WAIT_OP  = 4'd4;
   localparam logic [3:0] ST_SEND_B   = 4'd5;
   localparam logic [3:0] ST_WAIT_B   = 4'd6;
   localparam logic [3:0] ST_WAIT_RES = 4'd7;
   localparam logic [3:0] ST_DONE     = 4'd8;

   localparam int N_BYTES = 3;
   localparam logic [NB_TIMEOUT-1:0] CNT_LAST = NB_TIMEOUT'(TIMEOUT - 1);
   localparam logic [NB_TIMEOUT-1:0] CNT_MAX  = {NB_TIMEOUT{1'b1}};

   logic [3:0]            state_reg;
   logic [3:0]            state_next;
   logic [NB_TIMEOUT-1:0] cnt_reg;
   logic [NB_BITS-1:0]    req_in   [N_BYTES];
   logic [NB_BITS-1:0]    req_byte [N_BYTES];
   logic                  accept;
   logic                  sending;
   logic                  in_wait_res;
   logic                  timeout_hit;
   logic [NB_BITS-1:0]    send_byte;

   // Wire order of the request: operand A, opcode, operand B.
   assign req_in[0] = i_op_a;
   assign req_in[1] = i_opcode;
   assign req_in[2] = i_op_b;

   assign accept      = (state_reg == ST_IDLE) && i_start;
   assign in_wait_res = (state_reg == ST_WAIT_RES);
   assign timeout_hit = (cnt_reg == CNT_LAST);

   genvar gi;
   generate
      for (gi = 0; gi < N_BYTES; gi++) begin : g_req
         logic [NB_BITS-1:0] byte_reg;

         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
               byte_reg <= '0;
            end else if (accept) begin
               byte_reg <= req_in[gi];
            end
         end

         assign req_byte[gi] = byte_reg;
      end
   endgenerate

   always_comb begin
      sending   = 1'b0;
      send_byte = req_byte[0];
      case (state_reg)
         ST_SEND_A: begin
            sending   = 1'b1;
            send_byte = req_byte[0];
         end
         ST_SEND_OP: begin
            sending   = 1'b1;
            send_byte = req_byte[1];
         end
         ST_SEND_B: begin
            sending   = 1'b1;
            send_byte = req_byte[2];
         end
         default: begin
         end
      endcase
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:     if (i_start) state_next = ST_SEND_A;
         ST_SEND_A:   state_next = ST_WAIT_A;
         ST_WAIT_A:   if (i_tx_done) state_next = ST_SEND_OP;
         ST_SEND_OP:  state_next = ST_WAIT_OP;
         ST_WAIT_OP:  if (i_tx_done) state_next = ST_SEND_B;
         ST_SEND_B:   state_next = ST_WAIT_B;
         ST_WAIT_B:   if (i_tx_done) state_next = ST_WAIT_RES;
         ST_WAIT_RES: if (i_rx_done || timeout_hit) state_next = ST_DONE;
         ST_DONE:     state_next = ST_IDLE;
         default:     state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Counter sits at zero outside WAIT_RES, so entry always starts a fresh count.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_reg <= '0;
      end else if (!in_wait_res) begin
         cnt_reg <= '0;
      end else if (cnt_reg != CNT_MAX) begin
         cnt_reg <= cnt_reg + NB_TIMEOUT'(1);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_busy     <= 1'b0;
         o_result   <= '0;
         o_valid    <= 1'b0;
         o_timeout  <= 1'b0;
         o_tx_data  <= '0;
         o_tx_start <= 1'b0;
      end else begin
         o_busy     <= (state_next != ST_IDLE);
         o_tx_start <= sending;
         if (sending) begin
            o_tx_data <= send_byte;
         end
         // A response arriving on the last allowed cycle still counts as success.
         o_valid   <= in_wait_res && i_rx_done;
         o_timeout <= in_wait_res && !i_rx_done && timeout_hit;
         if (in_wait_res && i_rx_done) begin
            o_result <= i_rx_data;
         end
      end
   end

endmodule

// File: tb/tb_alu_uart_requester.sv
// Bench for alu_uart_requester: Tx/Rx UART stand-ins, an ALU responder and a
// request-level scoreboard checked every cycle, plus directed literal checks.
module tb_alu_uart_requester;

   localparam int TOUT     = 1000;
   localparam int TX_LAT   = 12;
   localparam int RESP_LAT = 25;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] op_a, op_b, opcode;
   logic       tx_done;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       busy;
   logic [7:0] result;
   logic       valid;
   logic       timeout;
   logic [7:0] tx_data;
   logic       tx_start;

   alu_uart_requester #(.NB_BITS(8), .NB_TIMEOUT(18), .TIMEOUT(TOUT)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start),
      .i_op_a(op_a), .i_op_b(op_b), .i_opcode(opcode),
      .o_busy(busy), .o_result(result), .o_valid(valid), .o_timeout(timeout),
      .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_done(tx_done),
      .i_rx_data(rx_data), .i_rx_done(rx_done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] exp_bytes[$];
   logic [7:0] exp_res[$];
   logic [7:0] tx_log[$];
   logic [7:0] m_result = 8'h00;
   int valid_cnt = 0, timeout_cnt = 0, tx_start_cnt = 0;
   int resp_delay = RESP_LAT;
   bit inj_req = 1'b0;
   logic [7:0] inj_data = 8'h00;
   int wres_cyc = 0;
   int n, v0, t0, s0;

   function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] op, input logic [7:0] b);
      case (op)
         8'h2B:   return a + b;
         8'h2D:   return a - b;
         8'h26:   return a & b;
         8'h7C:   return a | b;
         8'h5E:   return a ^ b;
         default: return 8'h00;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name, input string why);
      n_cmp++;
      n_err++;
      $display("FAIL %s: %s", name, why);
   endtask

   function automatic bit cond(input int sel);
      case (sel)
         0:       return tx_start;
         1:       return valid;
         2:       return timeout;
         3:       return !busy;
         default: return valid || timeout;
      endcase
   endfunction

   task automatic wait_until(input int sel, input int max_cyc, input string name, output int cnt);
      cnt = 0;
      while (!cond(sel)) begin
         if (cnt >= max_cyc) begin
            fail(name, $sformatf("event absent after %0d cycles, required within bound", cnt));
            return;
         end
         @(negedge clk);
         cnt++;
      end
   endtask

   // Request as the user sees it: the three bytes must go out, and the ALU answer
   // comes back unless the responder is silent or later than the allowed window.
   task automatic issue(input logic [7:0] a, input logic [7:0] op, input logic [7:0] b);
      exp_bytes.push_back(a);
      exp_bytes.push_back(op);
      exp_bytes.push_back(b);
      if (resp_delay > 0 && resp_delay <= TOUT) exp_res.push_back(alu(a, op, b));
      op_a = a; opcode = op; op_b = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Tx_uart stand-in: a byte takes TX_LAT cycles, then one done pulse.
   initial begin : tx_model
      int cnt;
      bit tx_busy;
      cnt = 0; tx_busy = 1'b0; tx_done = 1'b0;
      forever begin
         @(negedge clk);
         tx_done = 1'b0;
         if (rst) begin
            tx_busy = 1'b0;
         end else begin
            if (tx_busy) begin
               cnt--;
               if (cnt == 0) begin tx_done = 1'b1; tx_busy = 1'b0; end
            end
            if (tx_start) begin
               tx_busy = 1'b1; cnt = TX_LAT; tx_log.push_back(tx_data);
            end
         end
      end
   end

   // Remote ALU: after the third byte completes, answers resp_delay cycles later.
   initial begin : responder
      int seen, cnt;
      bit armed;
      logic [7:0] resp;
      seen = 0; cnt = 0; armed = 1'b0; resp = 8'h00;
      rx_done = 1'b0; rx_data = 8'h00;
      forever begin
         @(negedge clk); #1;
         rx_done = 1'b0;
         if (rst) begin
            seen = 0; armed = 1'b0;
         end else begin
            if (armed) begin
               cnt--;
               if (cnt == 0) begin rx_done = 1'b1; rx_data = resp; armed = 1'b0; end
            end
            if (inj_req) begin rx_done = 1'b1; rx_data = inj_data; inj_req = 1'b0; end
            if (tx_done) begin
               seen++;
               if (seen == 3) begin
                  seen = 0;
                  wres_cyc = cyc + 1;
                  if (resp_delay > 0) begin
                     armed = 1'b1; cnt = resp_delay;
                     resp = alu(tx_log[$-2], tx_log[$-1], tx_log[$]);
                  end
               end
            end
         end
      end
   end

   initial begin : compare
      bit prev_start;
      logic [7:0] last_tx;
      prev_start = 1'b0; last_tx = 8'h00;
      forever begin
         @(negedge clk); #2;
         if (rst) begin
            check("rst_busy", 32'(busy), 0);
            check("rst_tx_start", 32'(tx_start), 0);
            check("rst_tx_data", 32'(tx_data), 0);
            check("rst_result", 32'(result), 0);
            check("rst_valid", 32'(valid), 0);
            check("rst_timeout", 32'(timeout), 0);
            prev_start = 1'b0; last_tx = 8'h00;
         end else begin
            if (tx_start) begin
               tx_start_cnt++;
               check("tx_start_width", 32'(prev_start), 0);
               if (exp_bytes.size() == 0) fail("tx_unexpected", $sformatf("byte %0h sent, none required", tx_data));
               else check("tx_byte", 32'(tx_data), 32'(exp_bytes.pop_front()));
               last_tx = tx_data;
            end else if (busy) begin
               check("tx_data_hold", 32'(tx_data), 32'(last_tx));
            end
            if (valid) begin
               valid_cnt++;
               check("valid_no_timeout", 32'(timeout), 0);
               if (exp_res.size() == 0) fail("valid_unexpected", $sformatf("result %0h, no response required", result));
               else begin
                  m_result = exp_res.pop_front();
                  check("result", 32'(result), 32'(m_result));
               end
            end else begin
               check("result_held", 32'(result), 32'(m_result));
            end
            if (timeout) timeout_cnt++;
            prev_start = tx_start;
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin : main
      rst = 1'b1; start = 1'b0; op_a = 8'h00; op_b = 8'h00; opcode = 8'h00;
      repeat (3) @(negedge clk);
      check("reset_busy", 32'(busy), 0);
      check("reset_result", 32'(result), 0);
      check("reset_tx_start", 32'(tx_start), 0);
      rst = 1'b0;
      @(negedge clk);

      // T1: basic request
      issue(8'h53, 8'h2B, 8'h01);
      check("t1_busy_after_start", 32'(busy), 1);
      wait_until(0, 10, "t1_tx_start", n);
      check("t1_tx_latency", 32'(n + 1), 2);
      wait_until(1, 400, "t1_valid", n);
      check("t1_result", 32'(result), 'h54);
      check("t1_busy_in_done", 32'(busy), 1);
      @(negedge clk);
      check("t1_busy_idle", 32'(busy), 0);
      check("t1_tx_order", 32'({tx_log[$-2], tx_log[$-1], tx_log[$]}), 'h532B01);
      $display("T1 A=53 op=2B B=01 -> result=%0h", result);

      // T2: start during WAIT_OP is ignored
      v0 = valid_cnt; s0 = tx_start_cnt;
      issue(8'h50, 8'h2B, 8'h04);
      wait_until(0, 10, "t2_tx_a", n);
      @(negedge clk);
      wait_until(0, 40, "t2_tx_op", n);
      op_a = 8'h11; opcode = 8'h2D; op_b = 8'h22; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_until(1, 400, "t2_valid", n);
      check("t2_result", 32'(result), 'h54);
      repeat (60) @(negedge clk);
      check("t2_single_valid", 32'(valid_cnt - v0), 1);
      check("t2_tx_frames", 32'(tx_start_cnt - s0), 3);
      check("t2_tx_bytes", 32'({tx_log[$-2], tx_log[$-1], tx_log[$]}), 'h502B04);
      check("t2_idle", 32'(busy), 0);
      $display("T2 A=50 op=2B B=04 (mid-flight start ignored) -> result=%0h", result);

      // T3: silent responder, timeout
      resp_delay = 0; t0 = timeout_cnt;
      issue(8'h12, 8'h2B, 8'h34);
      wait_until(2, 2000, "t3_timeout", n);
      check("t3_timeout_latency", 32'(cyc - wres_cyc), 1000);
      check("t3_no_valid", 32'(valid), 0);
      check("t3_result_kept", 32'(result), 'h54);
      @(negedge clk);
      check("t3_idle", 32'(busy), 0);
      $display("T3 A=12 op=2B B=34 -> timeout, result=%0h", result);

      // T4: stray rx byte during WAIT_A
      resp_delay = RESP_LAT; v0 = valid_cnt;
      issue(8'h08, 8'h2B, 8'h08);
      check("t3_timeout_count", 32'(timeout_cnt - t0), 1);
      wait_until(0, 10, "t4_tx_a", n);
      inj_data = 8'hFF; inj_req = 1'b1;
      @(negedge clk); @(negedge clk);
      check("t4_stray_result", 32'(result), 'h54);
      check("t4_stray_valid", 32'(valid), 0);
      wait_until(1, 400, "t4_valid", n);
      check("t4_result", 32'(result), 'h10);
      repeat (20) @(negedge clk);
      check("t4_single_valid", 32'(valid_cnt - v0), 1);
      $display("T4 A=08 op=2B B=08 (stray FF ignored) -> result=%0h", result);

      // T5: reset during WAIT_B
      v0 = valid_cnt; t0 = timeout_cnt;
      issue(8'h33, 8'h7C, 8'h44);
      wait_until(0, 10, "t5_tx_a", n);
      @(negedge clk);
      wait_until(0, 40, "t5_tx_op", n);
      @(negedge clk);
      wait_until(0, 40, "t5_tx_b", n);
      repeat (5) @(negedge clk);
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      check("t5_async_busy", 32'(busy), 0);
      check("t5_async_tx_data", 32'(tx_data), 0);
      check("t5_async_result", 32'(result), 0);
      exp_bytes.delete(); exp_res.delete(); m_result = 8'h00;
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      repeat (TOUT + 200) @(negedge clk);
      check("t5_no_valid", 32'(valid_cnt - v0), 0);
      check("t5_no_timeout", 32'(timeout_cnt - t0), 0);
      check("t5_idle", 32'(busy), 0);
      $display("T5 A=33 op=7C B=44 -> abandoned by reset");
      issue(8'h40, 8'h26, 8'hC7);
      wait_until(1, 400, "t5_fresh_valid", n);
      check("t5_fresh_result", 32'(result), 'h40);
      check("t5_fresh_bytes", 32'({tx_log[$-2], tx_log[$-1], tx_log[$]}), 'h4026C7);
      $display("T5 A=40 op=26 B=C7 -> result=%0h", result);
      repeat (5) @(negedge clk);

      // T6: response lands on the timeout cycle
      resp_delay = TOUT; t0 = timeout_cnt;
      issue(8'h7F, 8'h2D, 8'h01);
      wait_until(4, 2000, "t6_outcome", n);
      check("t6_valid", 32'(valid), 1);
      check("t6_timeout", 32'(timeout), 0);
      check("t6_result", 32'(result), 'h7E);
      check("t6_latency", 32'(cyc - wres_cyc), 1000);
      repeat (5) @(negedge clk);
      check("t6_timeout_count", 32'(timeout_cnt - t0), 0);
      $display("T6 A=7F op=2D B=01 (answer on last cycle) -> result=%0h", result);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
